// File: rtl/pe_feed_ctrl.sv
// Operand sequencer in front of the parallel PE: walks both SRAMs, tags beats, captures results.
// Optional stall counter output perf_stall enabled by defining PE_FEED_CTRL_PERF_EN.
module pe_feed_ctrl #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_beats,
    input  logic [CNT_W-1:0]  cfg_outs,
    output logic              busy,
    output logic              done,
    output logic              nram_en,
    output logic [ADDR_W-1:0] nram_addr,
    input  logic [511:0]      nram_rdata,
    output logic              wram_en,
    output logic [ADDR_W-1:0] wram_addr,
    input  logic [511:0]      wram_rdata,
    output logic [511:0]      pe_neuron,
    output logic [511:0]      pe_weight,
    output logic [1:0]        pe_ctl,
    output logic              pe_vld,
    input  logic [31:0]       pe_result,
    input  logic              pe_vld_o,
    output logic [31:0]       res_data,
    output logic [CNT_W-1:0]  res_idx,
    output logic              res_vld,
    input  logic              res_rdy
`ifdef PE_FEED_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0]  beats_q;
    logic [CNT_W-1:0]  outs_q;
    logic [CNT_W-1:0]  beat;
    logic [CNT_W-1:0]  outc;
    logic [CNT_W-1:0]  pend_idx;
    logic [ADDR_W-1:0] waddr;
    logic              pend;

    logic start_ok;
    logic cfg_zero;
    logic is_last;
    logic last_out;
    logic blocked;
    logic issue;
    logic hs;
    logic fin;

    assign start_ok = (state == IDLE) && start;
    assign cfg_zero = (cfg_beats == '0) || (cfg_outs == '0);
    assign is_last  = (beat == beats_q - CNT_W'(1));
    assign last_out = (outc == outs_q - CNT_W'(1));
    assign hs       = res_vld && res_rdy;

    // A last beat may only go out once its result has a free slot to land in.
    assign blocked = (state == RUN) && is_last
                   && (pend || (res_vld && !res_rdy));
    assign issue   = (state == RUN) && !blocked;

    always_comb begin
        state_nx = state;
        fin      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !cfg_zero) state_nx = RUN;
            end
            RUN: begin
                if (issue && is_last && last_out) state_nx = DRAIN;
            end
            DRAIN: begin
                if (!pend && hs) begin
                    state_nx = IDLE;
                    fin      = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= fin || (start_ok && cfg_zero);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q  <= '0;
            outs_q   <= '0;
            beat     <= '0;
            outc     <= '0;
            pend_idx <= '0;
            waddr    <= '0;
        end else if (start_ok) begin
            beats_q <= cfg_beats;
            outs_q  <= cfg_outs;
            beat    <= '0;
            outc    <= '0;
            waddr   <= '0;
        end else if (issue) begin
            waddr <= waddr + ADDR_W'(1);
            if (is_last) begin
                beat     <= '0;
                outc     <= outc + CNT_W'(1);
                pend_idx <= outc;
            end else begin
                beat <= beat + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else if (issue && is_last) begin
            pend <= 1'b1;
        end else if (pe_vld_o) begin
            pend <= 1'b0;
        end
    end

    // One register stage aligns the tag with SRAM read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_vld <= 1'b0;
            pe_ctl <= 2'b00;
        end else begin
            pe_vld <= issue;
            pe_ctl <= issue ? {is_last, beat == '0} : 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_idx  <= '0;
            res_vld  <= 1'b0;
        end else if (pe_vld_o) begin
            res_data <= pe_result;
            res_idx  <= pend_idx;
            res_vld  <= 1'b1;
        end else if (hs) begin
            res_vld <= 1'b0;
        end
    end

`ifdef PE_FEED_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= '0;
        end else if (start_ok) begin
            perf_stall <= '0;
        end else if (blocked && perf_stall != 32'hFFFF_FFFF) begin
            perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

    assign busy      = (state != IDLE);
    assign nram_en   = issue;
    assign wram_en   = issue;
    assign nram_addr = ADDR_W'(beat);
    assign wram_addr = waddr;
    assign pe_neuron = nram_rdata;
    assign pe_weight = wram_rdata;

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Scoreboard bench for pe_feed_ctrl with SRAM and PE models.
// Random jobs plus directed timing, stall, zero-config and reset cases.
module tb_pe_feed_ctrl;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  cfg_beats;
    logic [CNT_W-1:0]  cfg_outs;
    logic              busy;
    logic              done;
    logic              nram_en;
    logic [ADDR_W-1:0] nram_addr;
    logic [511:0]      nram_rdata;
    logic              wram_en;
    logic [ADDR_W-1:0] wram_addr;
    logic [511:0]      wram_rdata;
    logic [511:0]      pe_neuron;
    logic [511:0]      pe_weight;
    logic [1:0]        pe_ctl;
    logic              pe_vld;
    logic [31:0]       pe_result;
    logic              pe_vld_o;
    logic [31:0]       res_data;
    logic [CNT_W-1:0]  res_idx;
    logic              res_vld;
    logic              res_rdy;
`ifdef PE_FEED_CTRL_PERF_EN
    logic [31:0]       perf_stall;
`endif

    pe_feed_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_beats(cfg_beats), .cfg_outs(cfg_outs),
        .busy(busy), .done(done),
        .nram_en(nram_en), .nram_addr(nram_addr),
        .nram_rdata(nram_rdata),
        .wram_en(wram_en), .wram_addr(wram_addr),
        .wram_rdata(wram_rdata),
        .pe_neuron(pe_neuron), .pe_weight(pe_weight),
        .pe_ctl(pe_ctl), .pe_vld(pe_vld),
        .pe_result(pe_result), .pe_vld_o(pe_vld_o),
        .res_data(res_data), .res_idx(res_idx),
        .res_vld(res_vld), .res_rdy(res_rdy)
`ifdef PE_FEED_CTRL_PERF_EN
        , .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // SRAM contents as a function of address
    function automatic logic [31:0] nv(int a);
        return 32'(a) * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    function automatic logic [31:0] wv(int a);
        return (32'(a) * 32'h85EB_CA6B) ^ 32'hC2B2_AE35;
    endfunction

    function automatic logic [511:0] line_n(int a);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = nv(a) + 32'(i);
        return l;
    endfunction

    function automatic logic [511:0] line_w(int a);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = wv(a) + 32'(i);
        return l;
    endfunction

    function automatic logic [31:0] dotp(logic [511:0] n,
                                         logic [511:0] w);
        logic [31:0] s = '0;
        for (int i = 0; i < 16; i++)
            s += n[32*i +: 32] * w[32*i +: 32];
        return s;
    endfunction

    function automatic logic [31:0] pe_next(logic [31:0] acc,
                                            logic clr,
                                            logic [511:0] n,
                                            logic [511:0] w);
        return (clr ? 32'd0 : acc) + dotp(n, w);
    endfunction

    always @(posedge clk) begin
        if (nram_en) nram_rdata <= line_n(int'(nram_addr));
        if (wram_en) wram_rdata <= line_w(int'(wram_addr));
    end

    logic [31:0] pe_acc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_acc    <= '0;
            pe_vld_o  <= 1'b0;
            pe_result <= '0;
        end else begin
            pe_vld_o <= pe_vld && pe_ctl[1];
            if (pe_vld) begin
                pe_acc <= pe_next(pe_acc, pe_ctl[0], pe_neuron, pe_weight);
                if (pe_ctl[1])
                    pe_result <= pe_next(pe_acc, pe_ctl[0],
                                         pe_neuron, pe_weight);
            end
        end
    end

    typedef struct {
        logic [ADDR_W-1:0] na;
        logic [ADDR_W-1:0] wa;
        logic [1:0]        ctl;
    } iss_t;

    typedef struct {
        logic [CNT_W-1:0] idx;
        logic [31:0]      data;
    } res_t;

    iss_t       iss_q[$];
    logic [1:0] ctl_q[$];
    res_t       res_q[$];

    // Expected behaviour from address arithmetic alone
    function automatic void push_job(int b, int o);
        logic [31:0] sum;
        int a;
        if (b == 0 || o == 0) return;
        for (int oo = 0; oo < o; oo++) begin
            sum = '0;
            for (int bb = 0; bb < b; bb++) begin
                a = (oo * b + bb) % (1 << ADDR_W);
                for (int i = 0; i < 16; i++)
                    sum += (nv(bb) + 32'(i)) * (wv(a) + 32'(i));
                iss_q.push_back('{ADDR_W'(bb), ADDR_W'(a),
                                  {bb == b - 1, bb == 0}});
            end
            res_q.push_back('{CNT_W'(oo), sum});
        end
    endfunction

    int rdy_mode    = 0;
    int rdy_release = 0;
    int start_cyc   = 0;
    int last_hs     = 0;
    logic zero_job  = 1'b0;

    initial begin
        res_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       res_rdy = 1'b1;
                1:       res_rdy = 1'($urandom_range(0, 1));
                default: res_rdy = (cyc >= rdy_release);
            endcase
        end
    end

    logic             prev_hold = 1'b0;
    logic [31:0]      prev_data;
    logic [CNT_W-1:0] prev_idx;

    initial begin
        iss_t e;
        res_t r;
        logic [1:0] c;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (wram_en !== nram_en)
                    chk("wram_en_eq_nram_en", wram_en, nram_en);
                if (nram_en) begin
                    chk("issue_expected", iss_q.size() > 0, 1);
                    if (iss_q.size() > 0) begin
                        e = iss_q.pop_front();
                        chk("nram_addr", nram_addr, e.na);
                        chk("wram_addr", wram_addr, e.wa);
                        ctl_q.push_back(e.ctl);
                        if (e.ctl[1])
                            chk("last_issue_slot_free",
                                !res_vld || res_rdy, 1);
                    end
                end
                if (pe_vld) begin
                    chk("pe_vld_expected", ctl_q.size() > 0, 1);
                    if (ctl_q.size() > 0) begin
                        c = ctl_q.pop_front();
                        chk("pe_ctl", pe_ctl, c);
                    end
                end
                if (prev_hold) begin
                    chk("hold_res_data", res_data, prev_data);
                    chk("hold_res_idx", res_idx, prev_idx);
                end
                if (res_vld && res_rdy) begin
                    chk("result_expected", res_q.size() > 0, 1);
                    if (res_q.size() > 0) begin
                        r = res_q.pop_front();
                        chk("res_idx", res_idx, r.idx);
                        chk("res_data", res_data, r.data);
                    end
                    last_hs = cyc;
                end
                if (done) begin
                    if (zero_job)
                        chk("done_zero_cfg_cycle", cyc, start_cyc + 1);
                    else
                        chk("done_after_handshake", cyc, last_hs + 1);
                    chk("results_left_at_done", res_q.size(), 0);
                    chk("issues_left_at_done", iss_q.size(), 0);
                    chk("busy_low_at_done", busy, 0);
                end
                prev_hold = res_vld && !res_rdy;
                prev_data = res_data;
                prev_idx  = res_idx;
            end
        end
    end

    task automatic start_job(int b, int o);
        @(posedge clk);
        #2;
        cfg_beats = CNT_W'(b);
        cfg_outs  = CNT_W'(o);
        start     = 1'b1;
        start_cyc = cyc;
        zero_job  = (b == 0 || o == 0);
        push_job(b, o);
        @(posedge clk);
        #2;
        start     = 1'b0;
        cfg_beats = CNT_W'($urandom);
        cfg_outs  = CNT_W'($urandom);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) chk("busy_after_start", busy, !zero_job);
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_nram_en"}, nram_en, 0);
        chk({tag, "_wram_en"}, wram_en, 0);
        chk({tag, "_pe_vld"}, pe_vld, 0);
        chk({tag, "_res_vld"}, res_vld, 0);
        chk({tag, "_pe_ctl"}, pe_ctl, 0);
        chk({tag, "_nram_addr"}, nram_addr, 0);
        chk({tag, "_wram_addr"}, wram_addr, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_idx"}, res_idx, 0);
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_beats = '0;
        cfg_outs  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Four-beat single output: exact cycle positions
        rdy_mode = 0;
        start_job(4, 1);
        for (k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("t1_nram_en_%0d", k), nram_en,
                k >= 1 && k <= 4);
            chk($sformatf("t1_res_vld_%0d", k), res_vld, k == 7);
            chk($sformatf("t1_done_%0d", k), done, k == 8);
        end

        // Single-beat outputs
        start_job(1, 3);
        wait_done();

        // Downstream stall for 10 cycles
        rdy_mode    = 2;
        rdy_release = cyc + 11;
        start_job(2, 2);
        wait_done();
`ifdef PE_FEED_CTRL_PERF_EN
        chk("perf_stall_nonzero", perf_stall != 0, 1);
`endif
        rdy_mode = 0;

        // Zero configuration
        start_job(0, 3);
        wait_done();
        start_job(5, 0);
        wait_done();

        // Start pulsed while busy
        start_job(3, 3);
        repeat (4) @(posedge clk);
        #2;
        cfg_beats = 8'd5;
        cfg_outs  = 8'd5;
        start     = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done();

        // Randomized jobs with random back-pressure
        rdy_mode = 1;
        for (int j = 0; j < 14; j++) begin
            start_job($urandom_range(1, 6), $urandom_range(1, 5));
            wait_done();
        end

        // Reset in the middle of a job
        start_job(5, 4);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        iss_q.delete();
        ctl_q.delete();
        res_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        rdy_mode = 0;
        start_job(2, 2);
        wait_done();

        repeat (3) @(negedge clk);
        chk("final_results_empty", res_q.size(), 0);
        chk("final_issues_empty", iss_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
